// File: rtl/wb_regfile.sv
// wb_regfile: writeback select plus the 2**ADDR_W x DATA_W architectural
// register file, with two decode read ports, a debug read port and a
// retired-write counter. R0 always reads as zero.
// Optional feature macro: WB_BYPASS_EN (write-through bypass on rs1/rs2).
module wb_regfile #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] wb_alu_result,
   input  logic [DATA_W-1:0] wb_read_data,
   input  logic [ADDR_W-1:0] wb_rd,
   input  logic              wb_reg_write,
   input  logic              wb_mem_to_reg,
   input  logic [ADDR_W-1:0] rs1_addr,
   input  logic [ADDR_W-1:0] rs2_addr,
   output logic [DATA_W-1:0] rs1_data,
   output logic [DATA_W-1:0] rs2_data,
   output logic [DATA_W-1:0] wb_data,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data,
   output logic [15:0]       retire_count
);

   localparam int NREG = 2 ** ADDR_W;

   logic [DATA_W-1:0] regs_q [NREG];
   logic [DATA_W-1:0] regs_d [NREG];
   logic [15:0]       retire_q;
   logic [15:0]       retire_d;
   logic              we_s;
   logic [DATA_W-1:0] wb_data_s;

   // Writeback value select and commit qualifier (reset kills the write).
   always_comb begin
      wb_data_s = wb_mem_to_reg ? wb_read_data : wb_alu_result;
      we_s      = wb_reg_write && (wb_rd != {ADDR_W{1'b0}}) && !rst;
   end

   // Next-state of the storage array and retire counter.
   always_comb begin
      regs_d   = regs_q;
      retire_d = retire_q;
      if (we_s) begin
         regs_d[wb_rd] = wb_data_s;
         retire_d      = retire_q + 16'd1;
      end else begin
         retire_d = retire_q;
      end
      // Entry 0 is never meaningful; keep it pinned at zero.
      regs_d[0] = {DATA_W{1'b0}};
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= {DATA_W{1'b0}};
         end
         retire_q <= 16'd0;
      end else begin
         regs_q   <= regs_d;
         retire_q <= retire_d;
      end
   end

   // Asynchronous read ports; index 0 reads zero, optional write-through.
   always_comb begin
      rs1_data = (rs1_addr == {ADDR_W{1'b0}}) ? {DATA_W{1'b0}} : regs_q[rs1_addr];
      rs2_data = (rs2_addr == {ADDR_W{1'b0}}) ? {DATA_W{1'b0}} : regs_q[rs2_addr];
`ifdef WB_BYPASS_EN
      // we_s already excludes wb_rd == 0, so index 0 can never be bypassed.
      if (we_s && (rs1_addr == wb_rd)) begin
         rs1_data = wb_data_s;
      end else begin
         rs1_data = rs1_data;
      end
      if (we_s && (rs2_addr == wb_rd)) begin
         rs2_data = wb_data_s;
      end else begin
         rs2_data = rs2_data;
      end
`endif
   end

   // Debug port always reflects stored contents, never the bypass.
   always_comb begin
      dbg_data = (dbg_addr == {ADDR_W{1'b0}}) ? {DATA_W{1'b0}} : regs_q[dbg_addr];
   end

   // Output drive for the writeback value and retire counter.
   always_comb begin
      wb_data      = wb_data_s;
      retire_count = retire_q;
   end

endmodule
